store_buffer: RTL and testbench

- Posted-write buffer between the core's data-memory port (memwrite/dataadr/writedata) and the data memory.
- Core stores retire in one cycle into a FIFO of DEPTH entries. The FIFO drains to memory over a valid/ready handshake, in order.
- Loads search the buffer for store-to-load forwarding. A fence input plus an empty flag support ordering.

---
 rtl/store_buffer.sv | 112 +++++++++++
 tb/tb_store_buffer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO between core stores and data memory,
// with youngest-match store-to-load forwarding and fence/empty ordering support.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            memwrite,
    input  logic [AW-1:0]   dataadr,
    input  logic [DW-1:0]   writedata,
    input  logic [DW/8-1:0] byteen,
    input  logic            memread,
    input  logic            fence,
    output logic            st_stall,
    output logic            ld_hit,
    output logic [DW-1:0]   ld_data,
    output logic            ld_stall,
    output logic            fence_stall,
    output logic            empty,
    output logic            mem_valid,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int BW = DW / 8;

    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [BW-1:0] be_q   [DEPTH];
    logic [BW-1:0] be_d   [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;

    logic          push, pop;
    logic          fwd_found, fwd_full;
    logic [DW-1:0] fwd_data;
    logic [PW-1:0] idx;

    // Stall depends on the current count only; a same-cycle pop does not free a slot.
    assign st_stall    = memwrite && (count_q == (PW+1)'(DEPTH));
    assign push        = memwrite && !st_stall && !reset;
    assign mem_valid   = (count_q != '0);
    assign pop         = mem_valid && mem_ready;
    assign empty       = (count_q == '0);
    assign fence_stall = fence && (count_q != '0);
    assign mem_addr    = addr_q[head_q];
    assign mem_wdata   = data_q[head_q];
    assign mem_be      = be_q[head_q];

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            addr_d[tail_q] = dataadr & ~AW'(3);
            data_d[tail_q] = writedata;
            be_d[tail_q]   = byteen;
            tail_d         = tail_q + PW'(1);
        end
        if (pop) head_d = head_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    // Only pre-edge state is searched, so a same-cycle push is invisible.
    always_comb begin
        fwd_found = 1'b0;
        fwd_full  = 1'b0;
        fwd_data  = '0;
        idx       = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (i < int'(count_q) && addr_q[idx][AW-1:2] == dataadr[AW-1:2]) begin
                fwd_found = 1'b1;
                fwd_full  = &be_q[idx];
                fwd_data  = data_q[idx];
            end
        end
    end

    assign ld_hit   = memread && fwd_found && fwd_full;
    assign ld_stall = memread && fwd_found && !fwd_full;
    assign ld_data  = ld_hit ? fwd_data : '0;

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        be_q   <= be_d;
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: enqueue/drain order, stalls, forwarding,
// fence, reset mid-drain and pointer wrap, with hand-computed expectations.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        reset, memwrite, memread, fence, mem_ready;
    logic [31:0] dataadr, writedata;
    logic [3:0]  byteen;
    logic        st_stall, ld_hit, ld_stall, fence_stall, empty, mem_valid;
    logic [31:0] ld_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .byteen(byteen), .memread(memread), .fence(fence),
        .st_stall(st_stall), .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
        .fence_stall(fence_stall), .empty(empty), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        memwrite = 1'b1; dataadr = a; writedata = d; byteen = be;
        tick();
        memwrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; memwrite = 1'b0; memread = 1'b0; fence = 1'b0; mem_ready = 1'b0;
        dataadr = '0; writedata = '0; byteen = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
        n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
        n_cmp++; if ({st_stall, ld_hit, ld_stall, fence_stall} !== 4'b0) begin n_fail++; $display("FAIL reset_stalls got=%b exp=0000", {st_stall, ld_hit, ld_stall, fence_stall}); end
        n_cmp++; if (ld_data !== 32'h0) begin n_fail++; $display("FAIL reset_ld_data got=%h exp=0", ld_data); end
    endtask

    task automatic test_single();
        mem_ready = 1'b1;
        store(32'd80, 32'd17, 4'hF);
        n_cmp++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", mem_valid); end
        n_cmp++; if ({mem_addr, mem_wdata, mem_be} !== {32'd80, 32'd17, 4'hF}) begin n_fail++; $display("FAIL single_head got=%h/%h/%h exp=50/11/f", mem_addr, mem_wdata, mem_be); end
        tick();
        n_cmp++; if (empty !== 1'b1 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got empty=%b valid=%b exp 1/0", empty, mem_valid); end
    endtask

    task automatic test_fill_stall();
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) store(32'(4 * k), 32'(k + 1), 4'hF);
        memwrite = 1'b1; dataadr = 32'd16; writedata = 32'd5; byteen = 4'hF;
        #1;
        n_cmp++; if (st_stall !== 1'b1 || empty !== 1'b0) begin n_fail++; $display("FAIL fill_full got stall=%b empty=%b exp 1/0", st_stall, empty); end
        mem_ready = 1'b1;
        #1;
        n_cmp++; if (st_stall !== 1'b1) begin n_fail++; $display("FAIL fill_stall_with_pop got=%b exp=1", st_stall); end
        n_cmp++; if (mem_wdata !== 32'd1 || mem_addr !== 32'd0) begin n_fail++; $display("FAIL fill_head0 got=%h@%h exp=1@0", mem_wdata, mem_addr); end
        tick();
        n_cmp++; if (st_stall !== 1'b0) begin n_fail++; $display("FAIL fill_stall_drop got=%b exp=0", st_stall); end
        n_cmp++; if (mem_wdata !== 32'd2) begin n_fail++; $display("FAIL fill_head1 got=%h exp=2", mem_wdata); end
        tick();
        memwrite = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (mem_valid !== 1'b1 || mem_wdata !== 32'(k + 3) || mem_addr !== 32'(8 + 4 * k)) begin
                n_fail++; $display("FAIL fill_order%0d got v=%b %h@%h exp %0d@%0d", k, mem_valid, mem_wdata, mem_addr, k + 3, 8 + 4 * k);
            end
            tick();
        end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_empty got=%b exp=1", empty); end
    endtask

    task automatic test_forward();
        mem_ready = 1'b0;
        store(32'h40, 32'hAAAA_AAAA, 4'hF);
        store(32'h40, 32'h5555_5555, 4'hF);
        memread = 1'b1; dataadr = 32'h42;
        #1;
        n_cmp++; if (ld_hit !== 1'b1 || ld_stall !== 1'b0 || ld_data !== 32'h5555_5555) begin n_fail++; $display("FAIL fwd_youngest got hit=%b stall=%b data=%h exp 1/0/55555555", ld_hit, ld_stall, ld_data); end
        dataadr = 32'h44;
        #1;
        n_cmp++; if (ld_hit !== 1'b0 || ld_stall !== 1'b0 || ld_data !== 32'h0) begin n_fail++; $display("FAIL fwd_miss got hit=%b stall=%b data=%h exp 0/0/0", ld_hit, ld_stall, ld_data); end
        memread = 1'b0; dataadr = 32'h40;
        #1;
        n_cmp++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin n_fail++; $display("FAIL fwd_noread got hit=%b data=%h exp 0/0", ld_hit, ld_data); end
        memwrite = 1'b1; memread = 1'b1; dataadr = 32'h44; writedata = 32'hCAFE_F00D; byteen = 4'hF;
        #1;
        n_cmp++; if (ld_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_same_cycle_push got hit=%b exp=0", ld_hit); end
        tick();
        memwrite = 1'b0;
        #1;
        n_cmp++; if (ld_hit !== 1'b1 || ld_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL fwd_after_push got hit=%b data=%h exp 1/cafef00d", ld_hit, ld_data); end
        memread = 1'b0; mem_ready = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fwd_drain got empty=%b exp=1", empty); end
    endtask

    task automatic test_partial();
        mem_ready = 1'b0;
        store(32'h40, 32'h0000_00EE, 4'b0001);
        memread = 1'b1; dataadr = 32'h40;
        #1;
        n_cmp++; if (ld_stall !== 1'b1 || ld_hit !== 1'b0) begin n_fail++; $display("FAIL part_stall got stall=%b hit=%b exp 1/0", ld_stall, ld_hit); end
        mem_ready = 1'b1;
        #1;
        n_cmp++; if (ld_stall !== 1'b1) begin n_fail++; $display("FAIL part_pop_cycle got stall=%b exp=1", ld_stall); end
        tick();
        n_cmp++; if (ld_stall !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL part_release got stall=%b empty=%b exp 0/1", ld_stall, empty); end
        // Older partial shadowed by a younger full-word store.
        memread = 1'b0; mem_ready = 1'b0;
        store(32'h40, 32'h0000_00EE, 4'b0001);
        store(32'h40, 32'h1234_5678, 4'hF);
        memread = 1'b1; dataadr = 32'h40;
        #1;
        n_cmp++; if (ld_hit !== 1'b1 || ld_stall !== 1'b0 || ld_data !== 32'h1234_5678) begin n_fail++; $display("FAIL part_shadowed got hit=%b stall=%b data=%h exp 1/0/12345678", ld_hit, ld_stall, ld_data); end
        memread = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL part_drain got empty=%b exp=1", empty); end
    endtask

    task automatic test_fence();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) store(32'(32'h100 + 4 * k), 32'(k), 4'hF);
        fence = 1'b1;
        #1;
        n_cmp++; if (fence_stall !== 1'b1) begin n_fail++; $display("FAIL fence_set got=%b exp=1", fence_stall); end
        mem_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_cmp++; if (fence_stall !== (k < 3)) begin n_fail++; $display("FAIL fence_drain%0d got=%b exp=%b", k, fence_stall, k < 3); end
        end
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) store(32'(32'h100 + 4 * k), 32'(k), 4'hF);
        mem_ready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (mem_valid !== 1'b0 || empty !== 1'b1 || fence_stall !== 1'b0) begin n_fail++; $display("FAIL fence_reset got valid=%b empty=%b fstall=%b exp 0/1/0", mem_valid, empty, fence_stall); end
        fence = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d, exp_a;
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) store(32'(32'h200 + 4 * k), 32'(32'h100 + k), 4'hF);
        mem_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            memwrite  = (c <= 8);
            dataadr   = (c <= 1) ? 32'h301 : 32'(32'h300 + 4 * (c - 1));
            writedata = (c == 0) ? 32'hA0 : 32'(32'hA0 + c - 1);
            byteen    = 4'hF;
            #1;
            exp_d = (c < 4) ? 32'(32'h100 + c) : 32'(32'hA0 + c - 4);
            exp_a = (c < 4) ? 32'(32'h200 + 4 * c) : 32'(32'h300 + 4 * (c - 4));
            n_cmp++; if (st_stall !== (memwrite && c == 0)) begin n_fail++; $display("FAIL b2b_stall%0d got=%b exp=%b", c, st_stall, c == 0); end
            n_cmp++; if (mem_valid !== 1'b1 || mem_wdata !== exp_d || mem_addr !== exp_a) begin
                n_fail++; $display("FAIL b2b_head%0d got v=%b %h@%h exp %h@%h", c, mem_valid, mem_wdata, mem_addr, exp_d, exp_a);
            end
            tick();
        end
        memwrite = 1'b0;
        #1;
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got=%b exp=1", empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_forward();
        test_partial();
        test_fence();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
